// File: rtl/lsu_align_if.sv
// Core-side request/response and RAM-side access signals of the load/store alignment unit.
// The master side is the core plus data RAM. The slave side is lsu_align.
interface lsu_align_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_r;
   logic [3:0]  mem_w;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_r, mem_w, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_r, mem_w, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: maps byte/half/word accesses onto a word RAM.
// An access that crosses a word boundary is split into two RAM cycles.
//
// state | meaning
// IDLE  | ready; decode and latch an incoming request
// ACC1  | access to the word holding the first byte
// ACC2  | access to the following word (split accesses only)
// RESP  | one-cycle response pulse
module lsu_align #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input logic        clk,
   input logic        rst,
   lsu_align_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] data_q, data_d;
   logic        mem_r_q, mem_r_d;
   logic [3:0]  mem_w_q, mem_w_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic [1:0]  acc_size;
   logic [1:0]  acc_off;
   logic [31:0] acc_wdata;
   logic [7:0]  lane_m8;
   logic [63:0] lane_w64;
   logic [1:0]  neg_off;

   function automatic logic [7:0] lane_mask(input logic [1:0] size_code, input logic [1:0] off);
      logic [7:0] base;
      case (size_code)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         default: base = 8'h0f;
      endcase
      return base << off;
   endfunction

   function automatic logic funct3_ok(input logic we, input logic [2:0] f3);
      return we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
   endfunction

   function automatic logic misaligned(input logic [1:0] size_code, input logic [1:0] off);
      return (size_code == 2'd1 && off[0]) || (size_code == 2'd2 && off != 2'd0);
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         3'd0:    r = {{24{d[7]}}, d[7:0]};
         3'd1:    r = {{16{d[15]}}, d[15:0]};
         3'd4:    r = {24'd0, d[7:0]};
         3'd5:    r = {16'd0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Lane mask and shifted store data over a two-word window: the low half is
   // the first access, the high half is the spill into the next word.
   always_comb begin
      acc_size  = (state_q == IDLE) ? bus.req_funct3[1:0] : f3_q[1:0];
      acc_off   = (state_q == IDLE) ? bus.req_addr[1:0]   : addr_q[1:0];
      acc_wdata = (state_q == IDLE) ? bus.req_wdata       : wdata_q;
      lane_m8   = lane_mask(acc_size, acc_off);
      lane_w64  = {32'd0, acc_wdata} << {acc_off, 3'b000};
      neg_off   = 2'd0 - addr_q[1:0];
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      f3_d         = f3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      data_d       = data_q;
      mem_r_d      = 1'b0;
      mem_w_d      = 4'd0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               f3_d    = bus.req_funct3;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (!funct3_ok(bus.req_we, bus.req_funct3) ||
                   (!ALLOW_MISALIGNED && misaligned(bus.req_funct3[1:0], bus.req_addr[1:0]))) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = ACC1;
                  mem_addr_d = {bus.req_addr[31:2], 2'b00};
                  mem_r_d    = !bus.req_we;
                  if (bus.req_we) begin
                     mem_w_d     = lane_m8[3:0];
                     mem_wdata_d = lane_w64[31:0];
                  end
               end
            end
         end
         ACC1: begin
            if (!we_q) data_d = bus.mem_rdata >> {addr_q[1:0], 3'b000};
            if (|lane_m8[7:4]) begin
               state_d    = ACC2;
               mem_addr_d = {addr_q[31:2] + 30'd1, 2'b00};
               mem_r_d    = !we_q;
               if (we_q) begin
                  mem_w_d     = lane_m8[7:4];
                  mem_wdata_d = lane_w64[63:32];
               end
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'd0 : extend(f3_q, data_d);
            end
         end
         ACC2: begin
            if (!we_q) data_d = data_q | (bus.mem_rdata << {neg_off, 3'b000});
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? 32'd0 : extend(f3_q, data_d);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         f3_q         <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         data_q       <= 32'd0;
         mem_r_q      <= 1'b0;
         mem_w_q      <= 4'd0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         f3_q         <= f3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         data_q       <= data_d;
         mem_r_q      <= mem_r_d;
         mem_w_q      <= mem_w_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   // The RAM commits on the falling edge, so strobes are masked during reset.
   assign bus.mem_r      = mem_r_q & ~rst;
   assign bus.mem_w      = mem_w_q & {4{~rst}};
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_lsu_align.sv
// Self-checking bench for lsu_align: directed cases plus random traffic against a byte-level RAM model.
// Two instances are used, one allowing and one rejecting misaligned accesses.
module tb_lsu_align;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        sel = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_f3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   logic [31:0] ram  [256];
   logic [31:0] mram [256];
   logic [31:0] last_rd;
   logic        last_err;

   lsu_align_if if1 ();
   lsu_align_if if0 ();

   lsu_align #(.ALLOW_MISALIGNED(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   lsu_align #(.ALLOW_MISALIGNED(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

   assign if1.req_valid  = req_valid & sel;
   assign if0.req_valid  = req_valid & ~sel;
   assign if1.req_we     = req_we;
   assign if0.req_we     = req_we;
   assign if1.req_funct3 = req_f3;
   assign if0.req_funct3 = req_f3;
   assign if1.req_addr   = req_addr;
   assign if0.req_addr   = req_addr;
   assign if1.req_wdata  = req_wdata;
   assign if0.req_wdata  = req_wdata;
   assign if1.mem_rdata  = ram[if1.mem_addr[9:2]];
   assign if0.mem_rdata  = ram[if0.mem_addr[9:2]];

   logic        o_ready, o_resp_valid, o_resp_err, o_mem_r;
   logic [3:0]  o_mem_w;
   logic [31:0] o_resp_rdata, o_mem_addr;
   assign o_ready      = sel ? if1.req_ready  : if0.req_ready;
   assign o_resp_valid = sel ? if1.resp_valid : if0.resp_valid;
   assign o_resp_err   = sel ? if1.resp_err   : if0.resp_err;
   assign o_resp_rdata = sel ? if1.resp_rdata : if0.resp_rdata;
   assign o_mem_r      = sel ? if1.mem_r      : if0.mem_r;
   assign o_mem_w      = sel ? if1.mem_w      : if0.mem_w;
   assign o_mem_addr   = sel ? if1.mem_addr   : if0.mem_addr;

   // RAM commits byte lanes on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (if1.mem_w[i]) ram[if1.mem_addr[9:2]][8*i +: 8] = if1.mem_wdata[8*i +: 8];
         if (if0.mem_w[i]) ram[if0.mem_addr[9:2]][8*i +: 8] = if0.mem_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_word(input logic [31:0] byte_addr, input logic [31:0] val);
      ram[byte_addr[9:2]]  = val;
      mram[byte_addr[9:2]] = val;
   endtask

   // Reference: an access is a sequence of consecutive bytes; the RAM split
   // follows from which word each byte lands in.
   task automatic run_req(input logic s, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
      int          sz, nacc, cycles, acc, nr;
      logic        valid, err, got_resp;
      logic [31:0] exp_rd, ba, ea, rd_seen;
      logic [3:0]  exp_w1, exp_w2;
      logic        err_seen;
      logic [31:0] addr_seen [4];
      logic [3:0]  w_seen [4];

      valid = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err   = !valid || (!s && (a % sz) != 0);
      nacc  = err ? 0 : ((int'(a[1:0]) + sz > 4) ? 2 : 1);
      exp_rd = 32'd0; exp_w1 = 4'd0; exp_w2 = 4'd0;
      if (!err) begin
         for (int k = 0; k < sz; k++) begin
            ba = a + k;
            if (we) begin
               mram[ba[9:2]][8*ba[1:0] +: 8] = wd[8*k +: 8];
               if (int'(a[1:0]) + k < 4) exp_w1[ba[1:0]] = 1'b1;
               else exp_w2[ba[1:0]] = 1'b1;
            end else begin
               exp_rd[8*k +: 8] = mram[ba[9:2]][8*ba[1:0] +: 8];
            end
         end
         if (!we && f3 == 3'd0 && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
         if (!we && f3 == 3'd1 && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
      end
      if (we || err) exp_rd = 32'd0;

      @(negedge clk);
      sel = s; req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
      #1 chk("ready", {31'd0, o_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_f3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;

      cycles = 0; acc = 0; nr = 0; got_resp = 1'b0; rd_seen = 32'd0; err_seen = 1'b0;
      while (!got_resp && cycles < 8) begin
         @(negedge clk);
         cycles++;
         if (o_mem_r || o_mem_w != 4'd0) begin
            if (acc < 4) begin
               addr_seen[acc] = o_mem_addr;
               w_seen[acc]    = o_mem_w;
            end
            acc++;
         end
         if (o_mem_r) nr++;
         if (o_resp_valid) begin
            got_resp = 1'b1;
            rd_seen  = o_resp_rdata;
            err_seen = o_resp_err;
         end
      end

      chk("resp_seen", {31'd0, got_resp}, 32'd1);
      chk("latency", cycles, nacc + 1);
      chk("resp_err", {31'd0, err_seen}, {31'd0, err});
      chk("resp_rdata", rd_seen, exp_rd);
      chk("n_access", acc, nacc);
      chk("n_read", nr, we ? 0 : nacc);
      if (nacc >= 1 && acc >= 1) begin
         chk("addr1", addr_seen[0], {a[31:2], 2'b00});
         chk("w1", {28'd0, w_seen[0]}, {28'd0, exp_w1});
      end
      if (nacc == 2 && acc >= 2) begin
         chk("addr2", addr_seen[1], {a[31:2] + 30'd1, 2'b00});
         chk("w2", {28'd0, w_seen[1]}, {28'd0, exp_w2});
      end
      if (we) begin
         ea = a + sz - 1;
         chk("ram_lo", ram[a[9:2]], mram[a[9:2]]);
         chk("ram_hi", ram[ea[9:2]], mram[ea[9:2]]);
      end
      last_rd  = rd_seen;
      last_err = err_seen;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]  = $urandom;
         mram[i] = ram[i];
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready1", {31'd0, if1.req_ready}, 32'd1);
      chk("rst_rvalid1", {31'd0, if1.resp_valid}, 32'd0);
      chk("rst_err1", {31'd0, if1.resp_err}, 32'd0);
      chk("rst_memr1", {31'd0, if1.mem_r}, 32'd0);
      chk("rst_memw1", {28'd0, if1.mem_w}, 32'd0);
      chk("rst_maddr1", if1.mem_addr, 32'd0);
      chk("rst_mwdata1", if1.mem_wdata, 32'd0);
      chk("rst_rdata1", if1.resp_rdata, 32'd0);
      chk("rst_maddr0", if0.mem_addr, 32'd0);
      chk("rst_rvalid0", {31'd0, if0.resp_valid}, 32'd0);
      rst = 1'b0;

      set_word(32'h100, 32'hDEADBEEF);
      run_req(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
      chk("lw_plan", last_rd, 32'hDEADBEEF);

      set_word(32'h200, 32'h80123456);
      run_req(1'b1, 1'b0, 3'd0, 32'h203, 32'd0);
      chk("lb_plan", last_rd, 32'hFFFFFF80);
      run_req(1'b1, 1'b0, 3'd4, 32'h203, 32'd0);
      chk("lbu_plan", last_rd, 32'h00000080);

      run_req(1'b1, 1'b1, 3'd2, 32'h302, 32'hAABBCCDD);
      chk("sw_plan_lo", {16'd0, ram[32'h300 >> 2][31:16]}, 32'h0000CCDD);
      chk("sw_plan_hi", {16'd0, ram[32'h304 >> 2][15:0]}, 32'h0000AABB);

      set_word(32'h400, 32'h7F000000);
      set_word(32'h404, 32'h00000080);
      run_req(1'b1, 1'b0, 3'd1, 32'h403, 32'd0);
      chk("lh_plan", last_rd, 32'hFFFF807F);
      run_req(1'b0, 1'b0, 3'd1, 32'h403, 32'd0);
      chk("lh_strict_err", {31'd0, last_err}, 32'd1);

      run_req(1'b1, 1'b0, 3'd3, 32'h500, 32'd0);
      run_req(1'b1, 1'b1, 3'd4, 32'h500, 32'h12345678);
      run_req(1'b1, 1'b0, 3'd6, 32'h501, 32'd0);
      run_req(1'b1, 1'b1, 3'd2, 32'hFFFFFFFE, 32'h11223344);
      run_req(1'b1, 1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
      chk("wrap_lw", last_rd, 32'h11223344);
      run_req(1'b0, 1'b1, 3'd2, 32'h610, 32'hCAFEF00D);
      run_req(1'b0, 1'b0, 3'd5, 32'h612, 32'd0);
      chk("lhu_strict", last_rd, 32'h0000CAFE);

      // Reset during the first access of a split halfword store.
      @(negedge clk);
      sel = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd1;
      req_addr = 32'h503; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_memw", {28'd0, o_mem_w}, 32'd0);
      chk("rst_mid_rvalid", {31'd0, o_resp_valid}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
      chk("rst_mid_rvalid2", {31'd0, o_resp_valid}, 32'd0);
      chk("rst_mid_ram0", ram[32'h500 >> 2 & 32'hFF], mram[32'h500 >> 2 & 32'hFF]);
      chk("rst_mid_ram1", ram[32'h504 >> 2 & 32'hFF], mram[32'h504 >> 2 & 32'hFF]);

      for (int n = 0; n < 300; n++) begin
         run_req(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
